// File: rtl/fifo_sync.sv
// fifo_sync: single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow error flags.
//
// Optional feature (compile-time macro): FIFO_FWFT_EN
//   defined   -> first-word-fall-through: datout shows the head entry whenever
//                the FIFO is non-empty, rd_en pops it.
//   undefined -> standard registered read with one cycle of latency.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   wr_en     in   write request
//   datin     in   write data [DATO_WIDTH]
//   rd_en     in   read request (standard) / pop acknowledge (FWFT)
//   clr_err   in   synchronous clear of overflow/underflow
//   datout    out  read data [DATO_WIDTH]
//   dato      out  datout holds valid data
//   full      out  count == depth
//   empy      out  count == 0
//   afull     out  count >= AFULL_THRESH
//   aempty    out  count <= AEMPTY_THRESH
//   count     out  occupancy 0..depth [FIFO_LENGTH+1]
//   overflow  out  sticky: a write was rejected
//   underflow out  sticky: a read was rejected
module fifo_sync #(
  parameter int unsigned DATO_WIDTH    = 8,
  parameter int unsigned FIFO_LENGTH   = 2,
  parameter int unsigned AFULL_THRESH  = (1 << FIFO_LENGTH) - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATO_WIDTH-1:0] datin,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATO_WIDTH-1:0] datout,
  output logic                  dato,
  output logic                  full,
  output logic                  empy,
  output logic                  afull,
  output logic                  aempty,
  output logic [FIFO_LENGTH:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 1 << FIFO_LENGTH;
  localparam int unsigned CntW  = FIFO_LENGTH + 1;

  localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);
  localparam logic [CntW-1:0] AFullCnt   = CntW'(AFULL_THRESH);
  localparam logic [CntW-1:0] AEmptyCnt  = CntW'(AEMPTY_THRESH);
  localparam logic [FIFO_LENGTH-1:0] PtrOne = FIFO_LENGTH'(1);

  logic [DATO_WIDTH-1:0]  mem_q [Depth];
  logic [FIFO_LENGTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   full_q, empy_q, afull_q, aempty_q;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic                   wr_acc, rd_acc;

  always_comb begin
    rd_acc  = rd_en & ~empy_q;
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    wr_acc  = wr_en & (~full_q | rd_acc);
    count_d = count_q + CntW'(wr_acc) - CntW'(rd_acc);
    // Setting has priority over clearing.
    ovf_d   = (wr_en & ~wr_acc) | (ovf_q & ~clr_err);
    unf_d   = (rd_en & ~rd_acc) | (unf_q & ~clr_err);
  end

  // Flags are registered from count_d so they line up with count every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empy_q   <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q  <= count_d;
      full_q   <= (count_d == DepthCnt);
      empy_q   <= (count_d == '0);
      afull_q  <= (count_d >= AFullCnt);
      aempty_q <= (count_d <= AEmptyCnt);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= datin;
  end

`ifdef FIFO_FWFT_EN
  assign datout = empy_q ? '0 : mem_q[rd_ptr_q];
  assign dato   = ~empy_q;
`else
  logic [DATO_WIDTH-1:0] datout_q;
  logic                  dato_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      datout_q <= '0;
      dato_q   <= 1'b0;
    end else begin
      if (rd_acc) datout_q <= mem_q[rd_ptr_q];
      dato_q <= rd_acc;
    end
  end

  assign datout = datout_q;
  assign dato   = dato_q;
`endif

  assign full      = full_q;
  assign empy      = empy_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync (D=4, AFULL_THRESH=3, AEMPTY_THRESH=1).
// A queue-based reference model tracks the expected contents and flags.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] datin;
  logic [7:0] datout;
  logic       dato, full, empy, afull, aempty, overflow, underflow;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_dout;
  bit         m_dato;

  fifo_sync #(
    .DATO_WIDTH   (8),
    .FIFO_LENGTH  (2),
    .AFULL_THRESH (3),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .datin    (datin),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .datout   (datout),
    .dato     (dato),
    .full     (full),
    .empy     (empy),
    .afull    (afull),
    .aempty   (aempty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  function automatic logic exp_dato();
`ifdef FIFO_FWFT_EN
    return mq.size() > 0;
`else
    return m_dato;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = 8'h00;
    m_dato = 1'b0;
  endfunction

  // One clock cycle of stimulus; the model advances from pre-edge state.
  task automatic drive(input logic we, input logic [7:0] din, input logic re,
                       input logic ce);
    bit ra, wa;
    @(negedge clk);
    wr_en = we; datin = din; rd_en = re; clr_err = ce;
    @(posedge clk);
    ra = re && (mq.size() > 0);
    wa = we && ((mq.size() < 4) || ra);
    m_dato = ra;
    if (ra) m_dout = mq.pop_front();
    if (wa) mq.push_back(din);
    m_ovf = (we && !wa) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_unf = (re && !ra) ? 1'b1 : (ce ? 1'b0 : m_unf);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if ({empy, aempty, full, afull} !== 4'b1100) begin
      bad++; $display("FAIL rst_flags got=%b want=1100", {empy, aempty, full, afull}); end
    total++; if ({dato, datout, overflow, underflow} !== 11'h0) begin
      bad++; $display("FAIL rst_out got=%b/%h/%b%b want=0", dato, datout, overflow, underflow); end
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL pre_rst_count got=%0d want=3", count); end
    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b0;
    model_reset();
    #1;
    total++; if (count !== 3'd0 || empy !== 1'b1 || aempty !== 1'b1) begin
      bad++; $display("FAIL midrst_state got=%0d/%b/%b want=0/1/1", count, empy, aempty); end
    total++; if (datout !== 8'h00 || dato !== 1'b0) begin
      bad++; $display("FAIL midrst_out got=%h/%b want=00/0", datout, dato); end
    @(negedge clk) rst = 1'b1;
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef FIFO_FWFT_EN
    total++; if (empy !== 1'b1) begin bad++; $display("FAIL post_rst_pop got=%b want=1", empy); end
`else
    total++; if (datout !== 8'h11 || dato !== 1'b1) begin
      bad++; $display("FAIL post_rst_rd got=%h/%b want=11/1", datout, dato); end
`endif
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      total++; if (afull !== (i >= 2)) begin
        bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, afull, (i >= 2)); end
      total++; if (full !== (i == 3) || count !== 3'(i + 1)) begin
        bad++; $display("FAIL fill_full[%0d] got=%b/%0d want=%b/%0d", i, full, count, (i == 3), i + 1); end
    end
    drive(1'b1, 8'hA4, 1'b0, 1'b0);
    total++; if (overflow !== 1'b1 || count !== 3'd4) begin
      bad++; $display("FAIL ovf got=%b/%0d want=1/4", overflow, count); end
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
      total++; if (datout !== 8'hA0 + 8'(i) || dato !== 1'b1) begin
        bad++; $display("FAIL drain[%0d] got=%h want=%h", i, datout, 8'hA0 + 8'(i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
`else
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (datout !== 8'hA0 + 8'(i) || dato !== 1'b1) begin
        bad++; $display("FAIL drain[%0d] got=%h want=%h", i, datout, 8'hA0 + 8'(i)); end
`endif
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (dato !== 1'b0 || empy !== 1'b1) begin
      bad++; $display("FAIL drain_end got=%b/%b want=0/1", dato, empy); end
`ifndef FIFO_FWFT_EN
    total++; if (datout !== 8'hA3) begin bad++; $display("FAIL hold got=%h want=a3", datout); end
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (underflow !== 1'b1 || dato !== 1'b0) begin
      bad++; $display("FAIL unf got=%b/%b want=1/0", underflow, dato); end
    // Set and clear together: set wins.
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_setwins got=%b want=1", underflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL err_clr got=%b%b want=00", overflow, underflow); end
  endtask

  task automatic test_wrap();
    int nread = 0;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) drive(1'b1, 8'(i), 1'b0, 1'b0);
      total++; if (count > 3'd2) begin bad++; $display("FAIL wrap_cnt got=%0d want<=2", count); end
`ifdef FIFO_FWFT_EN
      total++; if (datout !== 8'(nread)) begin
        bad++; $display("FAIL wrap_data got=%h want=%h", datout, 8'(nread)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
`else
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (datout !== 8'(nread) || dato !== 1'b1) begin
        bad++; $display("FAIL wrap_data got=%h/%b want=%h/1", datout, dato, 8'(nread)); end
`endif
      nread++;
    end
    total++; if (empy !== 1'b1) begin bad++; $display("FAIL wrap_end got=%b want=1", empy); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] want [4];
    want[0] = 8'hB1; want[1] = 8'hB2; want[2] = 8'hB3; want[3] = 8'hFF;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    total++; if (count !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL sim_full got=%0d/%b want=4/0", count, overflow); end
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
      total++; if (datout !== want[i]) begin
        bad++; $display("FAIL sim_drain[%0d] got=%h want=%h", i, datout, want[i]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
`else
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (datout !== want[i]) begin
        bad++; $display("FAIL sim_drain[%0d] got=%h want=%h", i, datout, want[i]); end
`endif
    end
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    total++; if (count !== 3'd1 || underflow !== 1'b1) begin
      bad++; $display("FAIL sim_empty got=%0d/%b want=1/1", count, underflow); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (datout !== 8'h5A || dato !== 1'b1) begin
      bad++; $display("FAIL fwft_show got=%h/%b want=5a/1", datout, dato); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (empy !== 1'b1 || dato !== 1'b0) begin
      bad++; $display("FAIL fwft_pop got=%b/%b want=1/0", empy, dato); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      total++; if (count !== 3'(mq.size())) begin
        bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", n, count, mq.size()); end
      total++; if ({full, empy, afull, aempty} !==
                   {mq.size() == 4, mq.size() == 0, mq.size() >= 3, mq.size() <= 1}) begin
        bad++; $display("FAIL rnd_flags[%0d] got=%b size=%0d", n, {full, empy, afull, aempty},
                        mq.size()); end
      total++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin
        bad++; $display("FAIL rnd_err[%0d] got=%b%b want=%b%b", n, overflow, underflow, m_ovf, m_unf); end
      total++; if (dato !== exp_dato()) begin
        bad++; $display("FAIL rnd_dato[%0d] got=%b want=%b", n, dato, exp_dato()); end
      total++; if (datout !== exp_dout()) begin
        bad++; $display("FAIL rnd_dout[%0d] got=%h want=%h", n, datout, exp_dout()); end
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; datin = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_wrap();
    test_simultaneous();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
